// File: rtl/pw_arm_sequencer_if.sv
// Signal bundle between the register/trigger side and the arm/re-arm sequencer.
// The master drives session controls and watched inputs; the slave (sequencer) drives status.
interface pw_arm_sequencer_if #(
  parameter int pSEGMENT_WIDTH = 8,
  parameter int pHOLDOFF_WIDTH = 16,
  parameter int pTIMEOUT_WIDTH = 24
);
  logic                      I_arm;
  logic                      I_abort;
  logic [pSEGMENT_WIDTH-1:0] I_num_segments;
  logic [pHOLDOFF_WIDTH-1:0] I_holdoff;
  logic [pTIMEOUT_WIDTH-1:0] I_timeout;
  logic                      I_match;
  logic                      I_capturing;
  logic                      O_capture_off;
  logic                      O_trigger_enable;
  logic                      O_armed;
  logic                      O_busy;
  logic                      O_done;
  logic                      O_timed_out;
  logic [pSEGMENT_WIDTH-1:0] O_segments_done;

  modport master (
    output I_arm, I_abort, I_num_segments, I_holdoff, I_timeout, I_match, I_capturing,
    input  O_capture_off, O_trigger_enable, O_armed, O_busy, O_done, O_timed_out,
           O_segments_done
  );

  modport slave (
    input  I_arm, I_abort, I_num_segments, I_holdoff, I_timeout, I_match, I_capturing,
    output O_capture_off, O_trigger_enable, O_armed, O_busy, O_done, O_timed_out,
           O_segments_done
  );
endinterface

// File: rtl/pw_arm_sequencer.sv
// Multi-segment arm/re-arm controller: sequences N match-initiated capture segments per
// session with inter-segment hold-off and an optional per-segment match timeout.
module pw_arm_sequencer #(
  parameter int pSEGMENT_WIDTH = 8,
  parameter int pHOLDOFF_WIDTH = 16,
  parameter int pTIMEOUT_WIDTH = 24
) (
  input  logic              fe_clk,
  input  logic              reset_n,
  pw_arm_sequencer_if.slave seq
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARMED,
    ST_CAPTURING,
    ST_HOLDOFF,
    ST_DONE
  } state_t;

  state_t                    state_q, state_d;
  logic [pSEGMENT_WIDTH-1:0] nseg_q, nseg_d;
  logic [pHOLDOFF_WIDTH-1:0] holdoff_q, holdoff_d;
  logic [pTIMEOUT_WIDTH-1:0] timeout_q, timeout_d;
  logic [pTIMEOUT_WIDTH-1:0] tcnt_q, tcnt_d;
  logic [pHOLDOFF_WIDTH-1:0] hcnt_q, hcnt_d;
  logic [pSEGMENT_WIDTH-1:0] seg_done_q, seg_done_d;
  logic [pSEGMENT_WIDTH-1:0] seg_next;
  logic                      timed_out_q, timed_out_d;
  logic                      cap_q;
  logic                      cap_fall;
  logic                      capture_off_q, capture_off_d;
  logic                      trig_en_q, trig_en_d;
  logic                      armed_q, armed_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;

  // Counters saturate rather than wrap.
  function automatic logic [pSEGMENT_WIDTH-1:0] seg_inc_sat(input logic [pSEGMENT_WIDTH-1:0] v);
    return (&v) ? v : v + pSEGMENT_WIDTH'(1);
  endfunction

  function automatic logic [pHOLDOFF_WIDTH-1:0] hold_inc_sat(input logic [pHOLDOFF_WIDTH-1:0] v);
    return (&v) ? v : v + pHOLDOFF_WIDTH'(1);
  endfunction

  function automatic logic [pTIMEOUT_WIDTH-1:0] tmo_inc_sat(input logic [pTIMEOUT_WIDTH-1:0] v);
    return (&v) ? v : v + pTIMEOUT_WIDTH'(1);
  endfunction

  assign cap_fall = cap_q & ~seq.I_capturing;

  always_comb begin
    state_d     = state_q;
    nseg_d      = nseg_q;
    holdoff_d   = holdoff_q;
    timeout_d   = timeout_q;
    tcnt_d      = tcnt_q;
    hcnt_d      = hcnt_q;
    seg_done_d  = seg_done_q;
    timed_out_d = timed_out_q;
    seg_next    = seg_inc_sat(seg_done_q);

    unique case (state_q)
      ST_IDLE: begin
        if (seq.I_arm && !seq.I_abort) begin
          nseg_d      = (seq.I_num_segments == '0) ? pSEGMENT_WIDTH'(1) : seq.I_num_segments;
          holdoff_d   = seq.I_holdoff;
          timeout_d   = seq.I_timeout;
          seg_done_d  = '0;
          timed_out_d = 1'b0;
          tcnt_d      = '0;
          state_d     = ST_ARMED;
        end
      end

      ST_ARMED: begin
        if (seq.I_abort) begin
          state_d = ST_IDLE;
        end else if (seq.I_match) begin
          state_d = ST_CAPTURING;
        end else if (timeout_q != '0) begin
          if (tcnt_q == timeout_q - pTIMEOUT_WIDTH'(1)) begin
            timed_out_d = 1'b1;
            state_d     = ST_DONE;
          end else begin
            tcnt_d = tmo_inc_sat(tcnt_q);
          end
        end
      end

      ST_CAPTURING: begin
        if (seq.I_abort) begin
          state_d = ST_IDLE;
        end else if (cap_fall) begin
          seg_done_d = seg_next;
          if (seg_next == nseg_q) begin
            state_d = ST_DONE;
          end else if (holdoff_q == '0) begin
            tcnt_d  = '0;
            state_d = ST_ARMED;
          end else begin
            hcnt_d  = '0;
            state_d = ST_HOLDOFF;
          end
        end
      end

      ST_HOLDOFF: begin
        if (seq.I_abort) begin
          state_d = ST_IDLE;
        end else if (hcnt_q == holdoff_q - pHOLDOFF_WIDTH'(1)) begin
          tcnt_d  = '0;
          state_d = ST_ARMED;
        end else begin
          hcnt_d = hold_inc_sat(hcnt_q);
        end
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase

    // Outputs are decoded from the next state so they line up with the state once registered.
    capture_off_d = (state_d != ST_ARMED);
    trig_en_d     = (state_d == ST_ARMED) || (state_d == ST_CAPTURING) || (state_d == ST_HOLDOFF);
    armed_d       = (state_d == ST_ARMED);
    busy_d        = (state_d != ST_IDLE);
    done_d        = (state_d == ST_DONE);
  end

  always_ff @(posedge fe_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      nseg_q        <= '0;
      holdoff_q     <= '0;
      timeout_q     <= '0;
      tcnt_q        <= '0;
      hcnt_q        <= '0;
      seg_done_q    <= '0;
      timed_out_q   <= 1'b0;
      cap_q         <= 1'b0;
      capture_off_q <= 1'b1;
      trig_en_q     <= 1'b0;
      armed_q       <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      nseg_q        <= nseg_d;
      holdoff_q     <= holdoff_d;
      timeout_q     <= timeout_d;
      tcnt_q        <= tcnt_d;
      hcnt_q        <= hcnt_d;
      seg_done_q    <= seg_done_d;
      timed_out_q   <= timed_out_d;
      cap_q         <= seq.I_capturing;
      capture_off_q <= capture_off_d;
      trig_en_q     <= trig_en_d;
      armed_q       <= armed_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign seq.O_capture_off    = capture_off_q;
  assign seq.O_trigger_enable = trig_en_q;
  assign seq.O_armed          = armed_q;
  assign seq.O_busy           = busy_q;
  assign seq.O_done           = done_q;
  assign seq.O_timed_out      = timed_out_q;
  assign seq.O_segments_done  = seg_done_q;

endmodule

// File: doc/pw_arm_sequencer.md
# pw_arm_sequencer

Multi-segment arm/re-arm controller for the PhyWhisperer trigger and capture path. It runs on `fe_clk` and sequences one acquisition session. A session consists of N pattern-match-initiated capture segments, with a programmable hold-off between segments and an optional per-segment match timeout. Its outputs drive the trigger block's capture-off and trigger-enable inputs. It watches the pattern matcher's match output and the capture block's capturing flag.

## Interface
Parameters:
- `pSEGMENT_WIDTH`, default 8: width of the segment count.
- `pHOLDOFF_WIDTH`, default 16: width of the inter-segment hold-off, in `fe_clk` cycles.
- `pTIMEOUT_WIDTH`, default 24: width of the per-segment match timeout, in `fe_clk` cycles.

Ports:
- `fe_clk`  in  1  sole clock. One clock; reset is asynchronous and active-low.
- `reset_n`  in  1  asynchronous, active-low reset.
- `I_arm`  in  1  single-cycle session start request, from the register block.
- `I_abort`  in  1  single-cycle session cancel request.
- `I_num_segments`  in  pSEGMENT_WIDTH  number of segments per session; 0 is treated as 1.
- `I_holdoff`  in  pHOLDOFF_WIDTH  cycles to wait after a capture ends before re-arming.
- `I_timeout`  in  pTIMEOUT_WIDTH  maximum number of cycles spent in ARMED per segment; 0 disables the timeout.
- `I_match`  in  1  pattern match pulse.
- `I_capturing`  in  1  capture-in-progress level, from the capture block.
- `O_capture_off`  out  1  registered; to the trigger block.
- `O_trigger_enable`  out  1  registered; to the trigger block.
- `O_armed`  out  1  high while the block is in ARMED.
- `O_busy`  out  1  high in any state except IDLE.
- `O_done`  out  1  single-cycle pulse at the end of a session.
- `O_timed_out`  out  1  sticky flag; cleared on the next accepted arm.
- `O_segments_done`  out  pSEGMENT_WIDTH  number of segments completed in the current or last session.

## Operation
- States: IDLE, ARMED, CAPTURING, HOLDOFF, DONE.
- Registered outputs are decoded from the next state, so each output is valid in the same cycle the block is in the corresponding state:
  - `O_capture_off` = (state != ARMED).
  - `O_trigger_enable` = state ∈ {ARMED, CAPTURING, HOLDOFF}.
  - `O_armed` = (state == ARMED).
  - `O_busy` = (state != IDLE).
- IDLE:
  - On `I_arm`, latch `I_num_segments` (0 becomes 1), `I_holdoff` and `I_timeout`.
  - Clear `O_segments_done`, `O_timed_out` and the timeout counter, then go to ARMED.
- ARMED:
  - The timeout counter increments by 1 per cycle.
  - On `I_match`, go to CAPTURING. The matching cycle itself still sees `O_capture_off` = 0, so the trigger block accepts that match. From the next cycle on, further matches are suppressed.
  - Else, if the timeout is nonzero and the counter equals timeout−1, set `O_timed_out` and go to DONE.
- CAPTURING:
  - Detect the falling edge of `I_capturing` using a registered copy of the signal.
  - On that edge, increment `O_segments_done`.
  - If the new count equals the latched segment count, go to DONE.
  - Else, if the hold-off is 0, go to ARMED; otherwise go to HOLDOFF.
  - `I_match` is ignored in this state.
- HOLDOFF:
  - Count `I_holdoff` cycles, then go to ARMED and clear the timeout counter.
  - `I_match` is ignored in this state.
- DONE: pulse `O_done` for one cycle, then go to IDLE.
- `I_abort` from any state other than IDLE or DONE: go to IDLE next cycle. No `O_done` pulse is produced; `O_segments_done` and `O_timed_out` are held.
- Arithmetic: all counters are unsigned and never wrap.
  - `O_segments_done` cannot exceed the latched segment count.
  - The timeout counter reaches at most timeout−1.

## Timing
- Reset (asynchronous assert, synchronous release):
  - State is IDLE.
  - `O_capture_off` = 1; `O_trigger_enable`, `O_armed`, `O_busy`, `O_done` and `O_timed_out` = 0.
  - `O_segments_done` = 0; all counters = 0.
- Reset asserted mid-session forces IDLE immediately, with no `O_done` pulse.
- Arm latency: `I_arm` sampled at cycle t gives `O_busy`, `O_armed` and `O_trigger_enable` = 1 and `O_capture_off` = 0 at t+1.
- A match in the same cycle as arm acceptance is ignored.
- Match to capture-off latency: `I_match` at t gives `O_capture_off` = 1 at t+1.
- End of segment: `I_capturing` first sampled low at t (having been high at t−1) makes `O_segments_done` increment at t+1.
  - At t+1 the state becomes DONE, ARMED or HOLDOFF.
  - For the last segment, `O_done` is high at t+1 and the block is in IDLE at t+2.
- Hold-off of H cycles: HOLDOFF lasts exactly H cycles, then ARMED.
- Simultaneous events, in priority order:
  - Abort beats everything.
  - In IDLE, abort together with arm stays IDLE.
  - In ARMED, a match on the timeout-expiry cycle is treated as a match.
  - `I_arm` while busy is ignored.
- Inputs latched on arm do not affect the session if changed afterwards.

## Test plan
- Single segment: arm, `I_match` 5 cycles later, `I_capturing` high for 10 cycles → `O_capture_off` rises the cycle after the match; `O_done` pulses; `O_segments_done` = 1.
- Three segments with hold-off 4 → HOLDOFF lasts exactly 4 cycles each time; matches during CAPTURING and HOLDOFF are ignored; `O_segments_done` = 3; one `O_done` pulse.
- Timeout 100 with no match → `O_timed_out` = 1 and `O_done` pulses 100 cycles after ARMED is entered; a match on cycle 100 instead gives CAPTURING.
- `I_num_segments` = 0, hold-off 0 → session behaves as one segment; with `I_num_segments` = 2 and hold-off 0, the block goes directly from CAPTURING back to ARMED.
- Abort in CAPTURING after 1 of 3 segments → IDLE next cycle, no `O_done`, `O_segments_done` = 1; arm and abort together in IDLE → stays IDLE.
- `reset_n` asserted in HOLDOFF → all outputs reach their reset values without a clock edge; a subsequent arm works normally.
